// File: rtl/game_pkg.sv
// Shared definitions for the game timer and the downstream score stage.
package game_pkg;

   // Width of the elapsed-seconds value handed to the score stage.
   localparam int TIMER_W = 11;

   // Timer FSM encoding; exported so the score stage can decode it.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_PAUSED   = 2'd2,
      ST_FINISHED = 2'd3
   } game_state_t;

   // Prescaler width for a given clock rate, never narrower than one bit.
   function automatic int presc_width(input int clk_hz);
      return (clk_hz > 1) ? $clog2(clk_hz) : 1;
   endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control pulses into the game timer and its registered status outputs.
// Handshake: clear/start/pause/solved are single-cycle pulses sampled on the
// rising clock edge; there is no ready/valid back-pressure, every status
// output is a plain register valid in every cycle.
interface game_timer_if;
   import game_pkg::*;

   logic               clear;
   logic               start;
   logic               pause;
   logic               solved;
   logic [TIMER_W-1:0] timer;
   logic [3:0]         sec_ones;
   logic [3:0]         sec_tens;
   logic [3:0]         min_ones;
   logic [3:0]         min_tens;
   logic               second_tick;
   logic               running;
   logic               done;
   logic               timeout;

   modport master (
      output clear, start, pause, solved,
      input  timer, sec_ones, sec_tens, min_ones, min_tens,
      input  second_tick, running, done, timeout
   );

   modport slave (
      input  clear, start, pause, solved,
      output timer, sec_ones, sec_tens, min_ones, min_tens,
      output second_tick, running, done, timeout
   );

endinterface

// File: rtl/bcd_mmss_counter.sv
// Incremental mm:ss BCD counter; advanced once per elapsed second so the
// display digits track the binary timer without any divider.
module bcd_mmss_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens
);

   // Ripple-carry the four digits on each increment: 9->0, 5->0, 9->0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else if (clear) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else if (inc) begin
         if (sec_ones != 4'd9) begin
            sec_ones <= sec_ones + 4'd1;
         end else begin
            sec_ones <= 4'd0;
            if (sec_tens != 4'd5) begin
               sec_tens <= sec_tens + 4'd1;
            end else begin
               sec_tens <= 4'd0;
               if (min_ones != 4'd9) begin
                  min_ones <= min_ones + 4'd1;
               end else begin
                  min_ones <= 4'd0;
                  // 2047 s is 34:07, so min_tens never wraps in practice.
                  min_tens <= (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/game_timer.sv
// Puzzle game timer: counts whole seconds from start until solved or
// saturation, with pause/resume and a BCD mm:ss view of the count.
module game_timer
   import game_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int MAX_SECONDS = 2047
) (
   input  logic        clk,
   input  logic        reset,
   game_timer_if.slave bus,
   output game_state_t state
);

   localparam int                 PRE_W     = presc_width(CLK_HZ);
   localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_HZ - 1);
   localparam logic [TIMER_W-1:0] TIMER_SAT = TIMER_W'(MAX_SECONDS);

   game_state_t        state_q, state_d;
   logic [PRE_W-1:0]   presc_q, presc_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [TIMER_W-1:0] timer_inc;
   logic               tick_q, tick_d;
   logic               timeout_q, timeout_d;
   logic               running_q, done_q;
   logic               wrap;

   assign wrap      = (presc_q == PRE_LAST);
   assign timer_inc = timer_q + 1'b1;

   // State and counter registers; status flags are decoded from the next
   // state so every output is registered and lines up with timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         timer_q   <= '0;
         tick_q    <= 1'b0;
         timeout_q <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         timer_q   <= timer_d;
         tick_q    <= tick_d;
         timeout_q <= timeout_d;
         running_q <= (state_d == ST_RUNNING);
         done_q    <= (state_d == ST_FINISHED);
      end
   end

   // Next-state logic; priority clear > solved > increment > pause.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      timer_d   = timer_q;
      tick_d    = 1'b0;
      timeout_d = timeout_q;
      if (bus.clear) begin
         state_d   = ST_IDLE;
         presc_d   = '0;
         timer_d   = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_d   = '0;
               timer_d   = '0;
               timeout_d = 1'b0;
               if (bus.start) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
               if (bus.solved) begin
                  // Solving on a wrap cycle swallows that second.
                  state_d   = ST_FINISHED;
                  timeout_d = 1'b0;
               end else if (wrap) begin
                  presc_d = '0;
                  timer_d = timer_inc;
                  tick_d  = 1'b1;
                  if (timer_inc >= TIMER_SAT) begin
                     state_d   = ST_FINISHED;
                     timeout_d = 1'b1;
                  end else if (bus.pause) begin
                     state_d = ST_PAUSED;
                  end
               end else begin
                  // The pause cycle itself is still a running cycle.
                  presc_d = presc_q + 1'b1;
                  if (bus.pause) state_d = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (bus.solved) begin
                  state_d   = ST_FINISHED;
                  timeout_d = 1'b0;
               end else if (bus.pause) begin
                  state_d = ST_RUNNING;
               end
            end
            ST_FINISHED: begin
               state_d = ST_FINISHED;
            end
            default: begin
               state_d   = ST_IDLE;
               presc_d   = '0;
               timer_d   = '0;
               timeout_d = 1'b0;
            end
         endcase
      end
   end

   bcd_mmss_counter u_bcd (
      .clk      (clk),
      .reset    (reset),
      .clear    (bus.clear),
      .inc      (tick_d),
      .sec_ones (bus.sec_ones),
      .sec_tens (bus.sec_tens),
      .min_ones (bus.min_ones),
      .min_tens (bus.min_tens)
   );

   assign bus.timer       = timer_q;
   assign bus.second_tick = tick_q;
   assign bus.running     = running_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign state           = state_q;

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clk cycles per elapsed second.
REQ-002 Parameter MAX_SECONDS, default 2047: saturation value of timer; legal range 1..2047.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous return to IDLE, one-cycle pulse.
REQ-006 start  input  1  begin counting from IDLE, one-cycle pulse.
REQ-007 pause  input  1  toggle RUNNING/PAUSED, one-cycle pulse.
REQ-008 solved  input  1  puzzle complete; freezes timer, one-cycle pulse.
REQ-009 timer  output  11  elapsed whole seconds, unsigned; feeds the score stage.
REQ-010 sec_ones, sec_tens, min_ones, min_tens  output  4 each  BCD mm:ss of timer.
REQ-011 second_tick  output  1  one-cycle pulse on each timer increment.
REQ-012 running  output  1  high in RUNNING only.
REQ-013 done  output  1  high in FINISHED.
REQ-014 timeout  output  1  high when FINISHED was entered by saturation, not by solved.

Function
REQ-015 FSM states SHALL be IDLE, RUNNING, PAUSED, FINISHED.
REQ-016 IDLE: timer, BCD digits, prescaler held at 0; start -> RUNNING with prescaler 0.
REQ-017 RUNNING: prescaler counts 0..CLK_HZ-1, then wraps to 0; on the wrap cycle timer increments by 1 and second_tick pulses in the same cycle as the new value.
REQ-018 First increment SHALL occur exactly CLK_HZ cycles after the cycle start is sampled.
REQ-019 RUNNING + pause -> PAUSED; prescaler and timer held, not cleared.
REQ-020 PAUSED + pause -> RUNNING; prescaler resumes from its held value.
REQ-021 RUNNING or PAUSED + solved -> FINISHED with done=1, timeout=0; timer frozen.
REQ-022 Increment that brings timer to MAX_SECONDS SHALL also move to FINISHED with done=1, timeout=1; timer never exceeds MAX_SECONDS.
REQ-023 FINISHED: all counters frozen; only clear or reset leaves it.
REQ-024 clear in any state -> IDLE next cycle; all outputs return to reset values.
REQ-025 Same-cycle priority: clear > solved > increment > pause; solved coinciding with a prescaler wrap SHALL suppress that increment and second_tick.
REQ-026 pause coinciding with a wrap: increment taken, then state toggles.
REQ-027 start outside IDLE, pause in IDLE/FINISHED, and solved in IDLE/FINISHED SHALL be ignored.
REQ-028 BCD digits maintained incrementally, no divider: sec_ones 9->0 carries to sec_tens, sec_tens 5->0 carries to min_ones, min_ones 9->0 carries to min_tens; updated in the same cycle as timer, always equal to timer in mm:ss.
REQ-029 All outputs SHALL be registered.
REQ-030 Prescaler width SHALL be $clog2(CLK_HZ), minimum 1.

Reset
REQ-031 reset SHALL force state IDLE, prescaler 0, timer 0, all BCD digits 0, and second_tick, running, done, timeout all 0, independent of clk.
REQ-032 Reset release mid-operation SHALL leave the block in IDLE; counting restarts only on a new start.

Structure
REQ-033 Shared package game_pkg SHALL hold the FSM state encoding and the 11-bit timer width constant used by this block and the score stage.
REQ-034 The BCD mm:ss chain SHALL be a sub-module, bcd_mmss_counter, with inputs clear/inc and the four digit outputs.

Verification (bench uses CLK_HZ=4)
REQ-035 start, then 40 cycles -> timer=10, 10 second_tick pulses, each 4 cycles apart, first at cycle 4.
REQ-036 Run to timer=3, pause, idle 20 cycles, pause -> timer stays 3 while paused; next tick arrives after the remaining prescaler count, not a full 4 cycles.
REQ-037 MAX_SECONDS=75, run to end -> timer=75, digits 0,1,1,5 (min_tens..sec_ones), done=1, timeout=1, no further ticks.
REQ-038 solved in the same cycle as the wrap at timer=7 -> timer stays 7, no second_tick, done=1, timeout=0.
REQ-039 Timer at 59 then one tick -> digits 0,1,0,0; then clear -> all zero, IDLE; start while FINISHED -> no change.
REQ-040 Assert reset mid-run at timer=12 -> all outputs 0 immediately; after release, timer stays 0 until start.
